icache_2way_param: RTL and testbench

- Parametrised 2-way set-associative instruction cache between CPU fetch (pc) and block-wide instruction memory.
- Generalises the direct-mapped 8-line/4-word icache: sets, words per block and tag width are parameters, there are two ways with LRU replacement, and the miss path is an explicit FSM that latches the miss address.
- CPU stalls on busywait.

---
 rtl/icache_2way_param.sv | 153 +++++++++++++++
 tb/tb_icache_2way_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_2way_param.sv
// icache_2way_param: 2-way set-associative instruction cache with LRU
// replacement and a three-state miss FSM (IDLE -> MEM_READ -> UPDATE).
// Optional macro ICACHE_PERF_EN adds saturating hit_count / miss_count outputs.
//
// Handshake: the CPU may consume 'instruction' in any cycle where busywait=0
// and must hold pc while busywait=1. Toward memory, mem_read is held with a
// stable mem_address until a cycle where mem_busywait=0; mem_readdata is
// taken in exactly that cycle.
module icache_2way_param #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   pc,
  output logic [31:0]                   instruction,
  output logic                          busywait,
  output logic                          mem_read,
  output logic [TAG_W+INDEX_W-1:0]      mem_address,
  input  logic [32*(2**OFFSET_W)-1:0]   mem_readdata,
  input  logic                          mem_busywait,
`ifdef ICACHE_PERF_EN
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count,
`endif
  output logic [1:0]                    fsm_state
);

  localparam int SETS    = 2 ** INDEX_W;
  localparam int BLOCK_W = 32 * (2 ** OFFSET_W);
  localparam int IDX_LO  = 2 + OFFSET_W;
  localparam int TAG_LO  = IDX_LO + INDEX_W;
  localparam int TOP     = TAG_LO + TAG_W;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2} state_t;

  state_t state, next_state;

  logic [SETS-1:0]    valid [2];
  logic [TAG_W-1:0]   tags  [2][SETS];
  logic [BLOCK_W-1:0] data  [2][SETS];
  logic [SETS-1:0]    lru;

  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_index;
  logic [BLOCK_W-1:0] fill_block;
  logic [31:0]        last_instr;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                hit0, hit1, hit;
  logic [BLOCK_W-1:0]  hit_block;
  logic [31:0]         hit_word;
  logic                victim;
  logic                unused_pc;

  assign offset    = pc[IDX_LO-1:2];
  assign index     = pc[TAG_LO-1:IDX_LO];
  assign tag       = pc[TOP-1:TAG_LO];
  assign unused_pc = ^{pc[31:TOP], pc[1:0]};
  assign fsm_state = state;

  // Hit detection and word select, purely from the current pc.
  always_comb begin
    hit0      = valid[0][index] && (tags[0][index] == tag);
    hit1      = valid[1][index] && (tags[1][index] == tag);
    hit       = hit0 || hit1;
    hit_block = hit1 ? data[1][index] : data[0][index];
    hit_word  = hit_block[{offset, 5'd0} +: 32];
  end

  // Fill victim: first invalid way (way0 preferred), otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (!valid[0][miss_index])      victim = 1'b0;
    else if (!valid[1][miss_index]) victim = 1'b1;
    else                            victim = lru[miss_index];
  end

  // Next-state logic for the miss FSM.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!hit) next_state = MEM_READ;
      MEM_READ: if (!mem_busywait) next_state = UPDATE;
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs: a hit only serves data in IDLE; otherwise the last word is held.
  always_comb begin
    busywait    = (state != IDLE) || !hit;
    mem_read    = (state == MEM_READ);
    mem_address = '0;
    if (state == MEM_READ) mem_address = {miss_tag, miss_index};
    instruction = ((state == IDLE) && hit) ? hit_word : last_instr;
  end

  // State, valid/LRU bookkeeping, miss latch, fill capture and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      valid[0]   <= '0;
      valid[1]   <= '0;
      lru        <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
      fill_block <= '0;
      last_instr <= '0;
`ifdef ICACHE_PERF_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (hit) begin
            lru[index] <= hit0;
            last_instr <= hit_word;
`ifdef ICACHE_PERF_EN
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            miss_tag   <= tag;
            miss_index <= index;
`ifdef ICACHE_PERF_EN
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        MEM_READ: if (!mem_busywait) fill_block <= mem_readdata;
        UPDATE: begin
          valid[victim][miss_index] <= 1'b1;
          lru[miss_index]           <= ~victim;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays need no reset; valid bits gate them.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      tags[victim][miss_index] <= miss_tag;
      data[victim][miss_index] <= fill_block;
    end
  end

endmodule

// File: tb/tb_icache_2way_param.sv
// tb_icache_2way_param: directed bench for icache_2way_param with an
// instruction scoreboard and a memory-address scoreboard.
module tb_icache_2way_param;

  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = 3;
  localparam int ADDR_W   = TAG_W + INDEX_W;
  localparam int BLOCK_W  = 32 * (2 ** OFFSET_W);

  logic               clock = 1'b0;
  logic               reset;
  logic [31:0]        pc;
  logic [31:0]        instruction;
  logic               busywait;
  logic               mem_read;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;
  logic [1:0]         fsm_state;
`ifdef ICACHE_PERF_EN
  logic [31:0]        hit_count;
  logic [31:0]        miss_count;
`endif

  int checks = 0;
  int fails  = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       last_exp = '0;
  bit                mon_en = 1'b0;
  int                mem_wait = 0;
  int                exp_hits = 0;
  int                exp_misses = 0;

  icache_2way_param #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
`ifdef ICACHE_PERF_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Block at address a: word w = a*256 + (w+1)*0x11, so address 0 gives
  // 0x11, 0x22, 0x33, 0x44.
  function automatic logic [BLOCK_W-1:0] mem_block(input logic [ADDR_W-1:0] a);
    logic [BLOCK_W-1:0] b;
    b = '0;
    for (int w = 0; w < 2 ** OFFSET_W; w++)
      b[w*32 +: 32] = {18'b0, a, 8'h00} + 32'((w + 1) * 17);
    return b;
  endfunction

  // ---------------- memory model ----------------
  initial begin
    int cnt;
    cnt = 0;
    mem_busywait = 1'b1;
    mem_readdata = {4{32'hDEAD_BEEF}};
    forever begin
      @(posedge clock);
      #1;
      if (mem_read) begin
        if (cnt < mem_wait) begin
          mem_busywait = 1'b1;
          mem_readdata = {4{32'hDEAD_BEEF}};
          cnt++;
        end else begin
          mem_busywait = 1'b0;
          mem_readdata = mem_block(mem_address);
          cnt = 0;
        end
      end else begin
        mem_busywait = 1'b1;
        mem_readdata = {4{32'hDEAD_BEEF}};
        cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (mon_en && reset) begin
        if (mem_read) begin
          check("busywait_during_mem_read", 32'(busywait), 32'd1);
          if (exp_addr_q.size() == 0) fail_event("unexpected_mem_read");
          else begin
            check("mem_address", 32'(mem_address), 32'(exp_addr_q[0]));
            if (!mem_busywait) void'(exp_addr_q.pop_front());
          end
        end
        if (!busywait) begin
          if (exp_q.size() == 0) fail_event("unexpected_instruction");
          else begin
            e = exp_q.pop_front();
            check("instruction", instruction, e);
            last_exp = e;
          end
        end else begin
          check("instruction_hold", instruction, last_exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the rising edge
  // that follows the cycle in which the word was delivered.
  task automatic access(input logic [31:0] a, input logic [31:0] exp_i, input bit miss,
                        input logic [ADDR_W-1:0] exp_a, input int wait_c, input bit toggle);
    int  stall;
    int  mr;
    int  exp_stall;
    int  exp_mr;
    bit  done;
    stall = 0;
    mr    = 0;
    done  = 1'b0;
    mem_wait = wait_c;
    exp_q.push_back(exp_i);
    if (miss) begin
      exp_addr_q.push_back(exp_a);
      exp_misses++;
    end
    exp_hits++;
    pc = a;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      if (!busywait) done = 1'b1;
      else begin
        stall++;
        if (mem_read) begin
          mr++;
          if (toggle) begin
            #1;
            pc = mem_busywait ? (a ^ 32'h0000_03F0) : a;
          end
        end
      end
    end
    if (!done) fail_event("access_timeout");
    exp_stall = miss ? wait_c + 3 : 0;
    exp_mr    = miss ? wait_c + 1 : 0;
    check("stall_cycles", 32'(stall), 32'(exp_stall));
    check("mem_read_cycles", 32'(mr), 32'(exp_mr));
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_busywait", 32'(busywait), 32'd1);
    check("rst_state", 32'(fsm_state), 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    pc    = 32'h0;
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs();
    @(posedge clock);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Cold miss, 2 memory wait cycles, then hits within the block.
    access(32'h000, 32'h0000_0011, 1'b1, 6'h00, 2, 1'b0);
    access(32'h004, 32'h0000_0022, 1'b0, 6'h00, 0, 1'b0);
    access(32'h008, 32'h0000_0033, 1'b0, 6'h00, 0, 1'b0);
    access(32'h00C, 32'h0000_0044, 1'b0, 6'h00, 0, 1'b0);

    // Second tag in set 0 fills way1; alternation all hits.
    access(32'h080, 32'h0000_0811, 1'b1, 6'h08, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      access(32'h000, 32'h0000_0011, 1'b0, 6'h00, 0, 1'b0);
      access(32'h080, 32'h0000_0811, 1'b0, 6'h00, 0, 1'b0);
    end
    // Third tag evicts way0 (tag0); tag1 survives, tag0 misses again.
    access(32'h100, 32'h0000_1011, 1'b1, 6'h10, 1, 1'b0);
    access(32'h080, 32'h0000_0811, 1'b0, 6'h00, 0, 1'b0);
    access(32'h000, 32'h0000_0011, 1'b1, 6'h00, 0, 1'b0);

    // Long memory wait with pc toggled during the stall.
    access(32'h0A4, 32'h0000_0A22, 1'b1, 6'h0A, 6, 1'b1);

    // Reset asserted in the second MEM_READ cycle.
    mem_wait = 4;
    exp_addr_q.push_back(6'h0C);
    pc = 32'h0C0;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("state_before_reset", 32'(fsm_state), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_addr_q.delete();
    last_exp   = '0;
    exp_hits   = 0;
    exp_misses = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    access(32'h000, 32'h0000_0011, 1'b1, 6'h00, 2, 1'b0);
    access(32'h004, 32'h0000_0022, 1'b0, 6'h00, 0, 1'b0);
    mon_en = 1'b0;

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
`ifdef ICACHE_PERF_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
